// File: rtl/comparator_operand_loader.sv
// Operand loader for the 4-bit magnitude comparator: debounces the load/clear
// buttons and sequences switch captures into operand A, then operand B.

module comparator_operand_loader_btn #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_deb;
    logic             r_deb_q;
    logic             w_s;

    assign w_s = r_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_deb   <= 1'b0;
            r_deb_q <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_deb_q <= r_deb;
            // Any return to the accepted level restarts the qualification count.
            if (w_s == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt != LAST) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_deb <= w_s;
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_deb & ~r_deb_q;
endmodule

module comparator_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_load,
    input  logic       btn_clear,
    output logic [3:0] a_val,
    output logic [3:0] b_val,
    output logic       operands_valid,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        SHOW   = 2'b10
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_a, w_a_nxt;
    logic [3:0] r_b, w_b_nxt;
    logic       r_valid, w_valid_nxt;
    logic       w_load_p, w_clear_p;

    comparator_operand_loader_btn #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_ld (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (btn_load),
        .o_press(w_load_p)
    );

    comparator_operand_loader_btn #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_cl (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (btn_clear),
        .o_press(w_clear_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT_A;
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_valid_nxt = r_valid;
        if (w_clear_p) begin
            w_state_nxt = WAIT_A;
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                WAIT_A: if (w_load_p) begin
                    w_a_nxt     = sw;
                    w_state_nxt = WAIT_B;
                end
                WAIT_B: if (w_load_p) begin
                    w_b_nxt     = sw;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = SHOW;
                end
                SHOW: if (w_load_p) begin
                    // A new pair starts; B keeps showing the old value until replaced.
                    w_a_nxt     = sw;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = WAIT_B;
                end
                default: begin
                    w_state_nxt = WAIT_A;
                    w_a_nxt     = '0;
                    w_b_nxt     = '0;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    assign a_val          = r_a;
    assign b_val          = r_b;
    assign operands_valid = r_valid;
    assign state          = r_state;
endmodule

// File: tb/tb_comparator_operand_loader.sv
// Directed bench for comparator_operand_loader with the default 4-cycle debounce.

module tb_comparator_operand_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sw = '0;
    logic       btn_load = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] a_val, b_val;
    logic       operands_valid;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    comparator_operand_loader dut (
        .clk           (clk),
        .rst           (rst),
        .sw            (sw),
        .btn_load      (btn_load),
        .btn_clear     (btn_clear),
        .a_val         (a_val),
        .b_val         (b_val),
        .operands_valid(operands_valid),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                             input logic ev, input logic [1:0] es);
        check({tag, ".a"},     20'(a_val),          20'(ea));
        check({tag, ".b"},     20'(b_val),          20'(eb));
        check({tag, ".valid"}, 20'(operands_valid), 20'(ev));
        check({tag, ".state"}, 20'(state),          20'(es));
    endtask

    task automatic press_load(input logic [3:0] v, input int hold);
        sw = v;
        btn_load = 1'b1;
        tick(hold);
        btn_load = 1'b0;
        tick(20);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        check_out("reset_async", 4'h0, 4'h0, 1'b0, 2'b00);
        tick(2);
        rst = 1'b0;
        tick(2);
        check_out("reset_released", 4'h0, 4'h0, 1'b0, 2'b00);

        // Normal pair with latency check: sampled at edge 0, captured at edge 6
        sw = 4'hA;
        btn_load = 1'b1;
        tick(6);
        check("lat_before.state", 20'(state), 20'(2'b00));
        tick(1);
        check("lat_at6.a", 20'(a_val), 20'h0000A);
        check("lat_at6.state", 20'(state), 20'(2'b01));
        tick(13);
        btn_load = 1'b0;
        tick(20);
        press_load(4'h5, 20);
        check_out("pair", 4'hA, 4'h5, 1'b1, 2'b10);

        // Clear alone
        btn_clear = 1'b1;
        tick(10);
        btn_clear = 1'b0;
        tick(20);
        check_out("clear", 4'h0, 4'h0, 1'b0, 2'b00);

        // Bounce rejection: 3 high, 3 low, 2 high
        sw = 4'h9;
        btn_load = 1'b1; tick(3);
        btn_load = 1'b0; tick(3);
        btn_load = 1'b1; tick(2);
        btn_load = 1'b0; tick(10);
        check_out("bounce", 4'h0, 4'h0, 1'b0, 2'b00);
        check("bounce.cnt", 20'(dut.u_ld.r_cnt), 20'h0);
        press_load(4'h9, 10);
        check_out("clean_after_bounce", 4'h9, 4'h0, 1'b0, 2'b01);

        // Clear priority over a simultaneous load in WAIT_B
        sw = 4'hE;
        btn_load  = 1'b1;
        btn_clear = 1'b1;
        tick(10);
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        tick(20);
        check_out("clear_prio", 4'h0, 4'h0, 1'b0, 2'b00);

        // Long hold in WAIT_A yields exactly one capture
        press_load(4'h6, 200);
        check_out("long_hold", 4'h6, 4'h0, 1'b0, 2'b01);

        // Build SHOW with A=3, B=C, then restart a pair with sw=7
        btn_clear = 1'b1;
        tick(10);
        btn_clear = 1'b0;
        tick(20);
        press_load(4'h3, 10);
        press_load(4'hC, 10);
        check_out("show_3c", 4'h3, 4'hC, 1'b1, 2'b10);
        press_load(4'h7, 10);
        check_out("restart", 4'h7, 4'hC, 1'b0, 2'b01);

        // Reset during a half-debounced press
        sw = 4'hF;
        btn_load = 1'b1;
        tick(3);
        #2 rst = 1'b1;
        #1;
        check_out("reset_midop", 4'h0, 4'h0, 1'b0, 2'b00);
        btn_load = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(20);
        check_out("after_reset", 4'h0, 4'h0, 1'b0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
